// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    `include "global.svh"

    // Which stall source currently owns the pipeline, highest priority last.
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_FBUSY,
        SRC_LOADUSE,
        SRC_MULDIV,
        SRC_MBUSY,
        SRC_EXC
    } stall_src_t;

    // Mul/div occupancy FSM: RUN while E is free, MDWAIT while a mul/div holds E.
    typedef enum logic {
        RUN,
        MDWAIT
    } md_state_t;

    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/global.svh
// Core-wide common types shared by every block of the MIPS core.
`ifndef GLOBAL_SVH
`define GLOBAL_SVH

typedef logic [31:0] word_t;

`endif

// File: rtl/pipe_ctrl_muldiv_timer.sv
// Mul/div timer: counts the remaining E-stage occupancy of a multi-cycle
// mul/div and flags the last occupied cycle so E can advance on its edge.
module pipe_ctrl_muldiv_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    input  logic i_hold,
    input  logic i_clear,
    output logic o_busy,
    output logic o_done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // State and counter registers; reset aborts any mul/div in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state: an exception clears everything, a memory stall freezes it.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (i_clear) begin
            w_state_nxt = RUN;
            w_count_nxt = '0;
        end else if (!i_hold) begin
            case (r_state)
                RUN: begin
                    if (i_start) begin
                        w_state_nxt = MDWAIT;
                        w_count_nxt = i_is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                MDWAIT: begin
                    if (r_count == CNT_ONE) begin
                        w_state_nxt = RUN;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign o_busy = (r_state == MDWAIT);
    assign o_done = (r_state == MDWAIT) && (r_count == CNT_ONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates the stall sources into per-stage
// enables/flushes and sequences branch and exception PC redirects.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  f_busy,
    input  logic  d_load_use,
    input  logic  e_muldiv_start,
    input  logic  e_is_div,
    input  logic  m_busy,
    input  logic  e_redirect,
    input  word_t e_target,
    input  logic  m_exception,
    input  word_t exc_vector,
    output logic  f_en,
    output logic  d_en,
    output logic  e_en,
    output logic  m_en,
    output logic  d_flush,
    output logic  e_flush,
    output logic  m_flush,
    output logic  redirect_valid,
    output word_t redirect_pc,
    output logic  muldiv_busy
);

    logic       w_md_busy;
    logic       w_md_done;
    logic       w_md_stall;
    stall_src_t w_src;
    logic       w_accept;
    logic       w_fire;
    logic       r_pend_valid;
    word_t      r_pend_pc;

    pipe_ctrl_muldiv_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_muldiv_timer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (e_muldiv_start),
        .i_is_div (e_is_div),
        .i_hold   (m_busy),
        .i_clear  (m_exception),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done)
    );

    // The last occupied cycle releases E so the result leaves on that edge.
    assign w_md_stall = e_muldiv_start || (w_md_busy && !w_md_done);

    // Fixed-priority selection of the stall source that owns this cycle.
    always_comb begin
        w_src = SRC_NONE;
        if (m_exception) begin
            w_src = SRC_EXC;
        end else if (m_busy) begin
            w_src = SRC_MBUSY;
        end else if (w_md_stall) begin
            w_src = SRC_MULDIV;
        end else if (d_load_use) begin
            w_src = SRC_LOADUSE;
        end else if (f_busy) begin
            w_src = SRC_FBUSY;
        end
    end

    // A branch is taken only when E advances without a higher-priority flush;
    // a pending target is released only once the whole pipe is free to move.
    assign w_accept = e_redirect && ((w_src == SRC_NONE) || (w_src == SRC_FBUSY));
    assign w_fire   = r_pend_valid && (w_src == SRC_NONE);

    // Pending redirect: holds a branch target until the outstanding fetch ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else if (m_exception) begin
            r_pend_valid <= 1'b0;
        end else if (w_accept && f_busy) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= e_target;
        end else if (w_fire) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Enables, flushes and redirect outputs from the winning stall source.
    always_comb begin
        f_en           = 1'b1;
        d_en           = 1'b1;
        e_en           = 1'b1;
        m_en           = 1'b1;
        d_flush        = 1'b0;
        e_flush        = 1'b0;
        m_flush        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!reset) begin
            f_en    = 1'b0;
            d_en    = 1'b0;
            e_en    = 1'b0;
            m_en    = 1'b0;
            d_flush = 1'b1;
            e_flush = 1'b1;
            m_flush = 1'b1;
        end else begin
            case (w_src)
                SRC_EXC: begin
                    d_flush        = 1'b1;
                    e_flush        = 1'b1;
                    m_flush        = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = exc_vector;
                end
                SRC_MBUSY: begin
                    f_en = 1'b0;
                    d_en = 1'b0;
                    e_en = 1'b0;
                    m_en = 1'b0;
                end
                SRC_MULDIV: begin
                    f_en    = 1'b0;
                    d_en    = 1'b0;
                    e_en    = 1'b0;
                    m_flush = 1'b1;
                end
                SRC_LOADUSE: begin
                    f_en    = 1'b0;
                    d_en    = 1'b0;
                    e_flush = 1'b1;
                end
                SRC_FBUSY: begin
                    f_en    = 1'b0;
                    d_flush = 1'b1;
                end
                default: begin
                end
            endcase
            if (w_accept) begin
                d_flush = 1'b1;
                if (!f_busy) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = e_target;
                end
            end else if (w_fire) begin
                d_flush        = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = r_pend_pc;
            end
        end
    end

    assign muldiv_busy = reset && (w_md_busy || e_muldiv_start);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural occupancy/redirect model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic  clk;
    logic  reset;
    logic  f_busy;
    logic  d_load_use;
    logic  e_muldiv_start;
    logic  e_is_div;
    logic  m_busy;
    logic  e_redirect;
    word_t e_target;
    logic  m_exception;
    word_t exc_vector;
    logic  f_en;
    logic  d_en;
    logic  e_en;
    logic  m_en;
    logic  d_flush;
    logic  e_flush;
    logic  m_flush;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  muldiv_busy;

    int assertCount = 0;
    int failCount   = 0;

    // Model state: E occupancy of the mul/div in flight and the held branch target.
    bit    mdActive   = 1'b0;
    int    mdUsed     = 0;
    bit    mdIsDiv    = 1'b0;
    bit    pendValid  = 1'b0;
    word_t pendTarget = '0;

    pipe_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .f_busy         (f_busy),
        .d_load_use     (d_load_use),
        .e_muldiv_start (e_muldiv_start),
        .e_is_div       (e_is_div),
        .m_busy         (m_busy),
        .e_redirect     (e_redirect),
        .e_target       (e_target),
        .m_exception    (m_exception),
        .exc_vector     (exc_vector),
        .f_en           (f_en),
        .d_en           (d_en),
        .e_en           (e_en),
        .m_en           (m_en),
        .d_flush        (d_flush),
        .e_flush        (e_flush),
        .m_flush        (m_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .muldiv_busy    (muldiv_busy)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic actual, input logic expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkWord(input string name, input word_t actual, input word_t expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic fb, input logic lu, input logic st, input logic dv,
                                 input logic mb, input logic rd, input word_t tgt,
                                 input logic ex, input word_t vec);
        @(posedge clk);
        #1;
        f_busy         = fb;
        d_load_use     = lu;
        e_muldiv_start = st;
        e_is_div       = dv;
        m_busy         = mb;
        e_redirect     = rd;
        e_target       = tgt;
        m_exception    = ex;
        exc_vector     = vec;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Per-cycle compare against the model, then advance the model past the coming edge.
    always @(negedge clk) begin : compareProc
        logic  xF, xD, xE, xM, xDf, xEf, xMf, xRv, xMdb;
        word_t xPc;
        bit    mdStall;
        bit    free;
        int    nCur;

        nCur    = mdIsDiv ? DIV_N : MULT_N;
        mdStall = e_muldiv_start || (mdActive && (mdUsed + 1 < nCur));
        xF = 1'b1; xD = 1'b1; xE = 1'b1; xM = 1'b1;
        xDf = 1'b0; xEf = 1'b0; xMf = 1'b0;
        xRv = 1'b0; xPc = '0;
        xMdb = e_muldiv_start || mdActive;
        free = 1'b0;

        if (!reset) begin
            xF = 1'b0; xD = 1'b0; xE = 1'b0; xM = 1'b0;
            xDf = 1'b1; xEf = 1'b1; xMf = 1'b1;
            xMdb = 1'b0;
        end else if (m_exception) begin
            xDf = 1'b1; xEf = 1'b1; xMf = 1'b1;
            xRv = 1'b1; xPc = exc_vector;
        end else if (m_busy) begin
            xF = 1'b0; xD = 1'b0; xE = 1'b0; xM = 1'b0;
        end else if (mdStall) begin
            xF = 1'b0; xD = 1'b0; xE = 1'b0; xMf = 1'b1;
        end else if (d_load_use) begin
            xF = 1'b0; xD = 1'b0; xEf = 1'b1;
        end else begin
            free = 1'b1;
            if (f_busy) begin
                xF = 1'b0; xDf = 1'b1;
            end
            if (e_redirect) begin
                xDf = 1'b1;
                if (!f_busy) begin
                    xRv = 1'b1; xPc = e_target;
                end
            end else if (pendValid && !f_busy) begin
                xDf = 1'b1; xRv = 1'b1; xPc = pendTarget;
            end
        end

        checkBit("f_en", f_en, xF);
        checkBit("d_en", d_en, xD);
        checkBit("e_en", e_en, xE);
        checkBit("m_en", m_en, xM);
        checkBit("d_flush", d_flush, xDf);
        checkBit("e_flush", e_flush, xEf);
        checkBit("m_flush", m_flush, xMf);
        checkBit("redirect_valid", redirect_valid, xRv);
        checkWord("redirect_pc", redirect_pc, xPc);
        checkBit("muldiv_busy", muldiv_busy, xMdb);

        if (!reset || m_exception) begin
            mdActive  = 1'b0;
            mdUsed    = 0;
            pendValid = 1'b0;
        end else if (!m_busy) begin
            if (mdActive) begin
                if (mdUsed + 1 == nCur) mdActive = 1'b0;
                else mdUsed++;
            end else if (e_muldiv_start) begin
                mdActive = 1'b1;
                mdUsed   = 1;
                mdIsDiv  = e_is_div;
            end
            if (free && e_redirect && f_busy) begin
                pendValid  = 1'b1;
                pendTarget = e_target;
            end else if (free && pendValid && !f_busy && !e_redirect) begin
                pendValid = 1'b0;
            end
        end
    end

    // Directed scenarios with hand-computed literal expectations.
    initial begin : stimulusProc
        reset = 1'b0;
        f_busy = 1'b0; d_load_use = 1'b0; e_muldiv_start = 1'b0; e_is_div = 1'b0;
        m_busy = 1'b0; e_redirect = 1'b0; e_target = '0; m_exception = 1'b0; exc_vector = '0;
        #2;
        checkBit("rst_f_en", f_en, 1'b0);
        checkBit("rst_d_flush", d_flush, 1'b1);
        checkBit("rst_m_flush", m_flush, 1'b1);
        checkWord("rst_redirect_pc", redirect_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Idle pipeline, no hazards.
        for (int k = 0; k < 10; k++) begin
            idleCycle();
            #3;
            checkBit("idle_f_en", f_en, 1'b1);
            checkBit("idle_redirect_valid", redirect_valid, 1'b0);
        end

        // Divide: E held for 31 cycles, released in the 32nd.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        checkBit("div_issue_e_en", e_en, 1'b0);
        checkBit("div_issue_m_flush", m_flush, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            idleCycle();
            #3;
            if (k == 30) checkBit("div_k30_e_en", e_en, 1'b0);
            if (k == 31) begin
                checkBit("div_last_e_en", e_en, 1'b1);
                checkBit("div_last_m_flush", m_flush, 1'b0);
                checkBit("div_last_busy", muldiv_busy, 1'b1);
            end
            if (k == 32) checkBit("div_after_busy", muldiv_busy, 1'b0);
        end

        // Multiply with a three-cycle memory stall right after issue.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            if (k <= 3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            else idleCycle();
            #3;
            if (k == 2) checkBit("mul_mbusy_m_en", m_en, 1'b0);
            if (k == 5) checkBit("mul_k5_e_en", e_en, 1'b0);
            if (k == 6) checkBit("mul_release_e_en", e_en, 1'b1);
            if (k == 7) checkBit("mul_after_busy", muldiv_busy, 1'b0);
        end

        // Immediate branch redirect with the fetch idle.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 32'h0);
        #3;
        checkBit("br_now_valid", redirect_valid, 1'b1);
        checkWord("br_now_pc", redirect_pc, 32'h0040_0020);
        checkBit("br_now_d_en", d_en, 1'b1);
        idleCycle();
        #3;
        checkBit("br_now_after_valid", redirect_valid, 1'b0);

        // Branch while the fetch stays busy for three more cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0);
        #3;
        checkBit("br_pend_valid0", redirect_valid, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            #3;
            checkBit("br_pend_busy_valid", redirect_valid, 1'b0);
        end
        idleCycle();
        #3;
        checkBit("br_pend_fire_valid", redirect_valid, 1'b1);
        checkWord("br_pend_fire_pc", redirect_pc, 32'hBFC0_0100);
        checkBit("br_pend_fire_d_flush", d_flush, 1'b1);
        idleCycle();
        #3;
        checkBit("br_pend_done_valid", redirect_valid, 1'b0);

        // Exception during MDWAIT with a redirect pending.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        checkBit("exc_pre_e_en", e_en, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380);
        #3;
        checkWord("exc_pc", redirect_pc, 32'hBFC0_0380);
        checkBit("exc_e_flush", e_flush, 1'b1);
        checkBit("exc_m_en", m_en, 1'b1);
        idleCycle();
        #3;
        checkBit("exc_after_busy", muldiv_busy, 1'b0);
        checkBit("exc_after_d_flush", d_flush, 1'b0);
        checkBit("exc_after_valid", redirect_valid, 1'b0);

        // Exception and branch together: the branch is discarded.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b1, 32'hBFC0_0380);
        #3;
        checkWord("exc_br_pc", redirect_pc, 32'hBFC0_0380);
        idleCycle();
        #3;
        checkBit("exc_br_after_valid", redirect_valid, 1'b0);

        // Sweep of memory-busy / load-use / fetch-busy combinations.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(v[0], v[1], 1'b0, 1'b0, v[2], 1'b0, 32'h0, 1'b0, 32'h0);
        end

        // Load-use together with a busy fetch.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        checkBit("lu_fb_e_flush", e_flush, 1'b1);
        checkBit("lu_fb_f_en", f_en, 1'b0);
        checkBit("lu_fb_d_en", d_en, 1'b0);
        checkBit("lu_fb_d_flush", d_flush, 1'b0);

        // Reset pulled low in the middle of a divide.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) idleCycle();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkBit("midrst_e_en", e_en, 1'b0);
        checkBit("midrst_d_flush", d_flush, 1'b1);
        checkBit("midrst_busy", muldiv_busy, 1'b0);
        checkBit("midrst_valid", redirect_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idleCycle();
        #3;
        checkBit("postrst_busy", muldiv_busy, 1'b0);
        checkBit("postrst_e_en", e_en, 1'b1);
        checkBit("postrst_m_flush", m_flush, 1'b0);

        repeat (3) idleCycle();
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
